chip8_arith_sequencer: RTL and testbench
========================================

# chip8_arith_sequencer

- Multi-cycle controller that executes Chip-8 register-arithmetic instructions (8XYN).
- Reads VX and VY from the V register file, drives the shared 16-bit ALU with the correct function select and operands, then writes the 8-bit result to VX and the flag to VF.
- Sits inside the CPU between the instruction decoder, which issues one opcode per start handshake, and the V register file and ALU.

## Interface
Parameters: none.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  decoder request; sampled only when busy=0
- opcode  in  16  instruction word; must be 8XYN; captured on accepted start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- error  out  1  high with done when N is illegal
- reg_raddr  out  4  V register file read address (synchronous read, 1-cycle latency)
- reg_rdata  in  8  read data
- reg_we  out  1  write strobe
- reg_waddr  out  4  write address
- reg_wdata  out  8  write data
- alu_in1, alu_in2  out  16  ALU operands, zero-extended from 8 bits
- alu_sel  out  ALU_f  ALU function select
- alu_out  in  16  ALU result
- alu_carry  in  1  ALU carry

## Operation
States: S_IDLE, S_RDX, S_RDY, S_EXEC, S_WRX, S_WRF, S_DONE.

- **S_IDLE**
  - start=1 latches X=opcode[11:8], Y=opcode[7:4], N=opcode[3:0].
  - Legal N goes to S_RDX. Illegal N (4'h8–4'hD, 4'hF) goes to S_DONE with error set.
- **S_RDX**: reg_raddr=X.
- **S_RDY**: reg_raddr=Y; vx_q ← reg_rdata.
- **S_EXEC**: drive the ALU from vx_q and reg_rdata (VY). Capture res_q ← alu_out[7:0] and flag_q, per opcode:
  - N=0: alu_sel=OR, in1=VY, in2=0. No VF write.
  - N=1/2/3: OR / AND / XOR with in1=VX, in2=VY. No VF write.
  - N=4: ADD; flag=alu_carry.
  - N=5: MINUS with in1=VX, in2=VY; flag=(VX>=VY), computed locally.
  - N=7: MINUS with in1=VY, in2=VX; flag=(VY>=VX), computed locally.
  - N=6: RSHIFT with in1=VX, in2=1; flag=VX[0].
  - N=E: LSHIFT with in1=VX, in2=1; flag=VX[7]; result truncated to 8 bits.
  - All flags are computed from the pre-write operand values.
- **S_WRX**: reg_we=1, waddr=X, wdata=res_q. Go to S_WRF if the opcode sets a flag (N ∈ {4,5,6,7,E}), else S_DONE.
- **S_WRF**: reg_we=1, waddr=4'hF, wdata={7'b0,flag_q}.
- **S_DONE**: done=1 (error=1 only on the illegal path), then S_IDLE.
- Outside S_EXEC, alu_sel is held at ALU_f_OR and the operands at 0.

## Timing
- Reset (async assert, sync deassert):
  - State goes to S_IDLE.
  - busy, done, error, reg_we = 0; all addresses, data and ALU operands = 0.
  - Internal registers are cleared.
- Reset mid-operation: any in-flight write is abandoned and no reg_we pulse appears after reset_n falls.
- Accepted start at edge 0 gives:
  - S_RDX in cycle 1, S_RDY in cycle 2, S_EXEC in cycle 3, S_WRX in cycle 4.
  - done in cycle 5 for no-flag ops.
  - S_WRF in cycle 5 and done in cycle 6 for flag ops.
  - Illegal N: done+error in cycle 1.
- busy is high in every non-IDLE state. It falls together with the transition S_DONE→S_IDLE, so a new start can be sampled in the cycle after done.
- start while busy=1 is ignored: no queueing, no error.
- X=F: VX is written first and the flag write in S_WRF overwrites it, so VF holds the flag.
- X=Y: both reads return the same value. Examples: 8XX5 gives VX=0, VF=1; 8XX4 doubles VX.

## Structure
- Add the sequencer state typedef and the opcode N constants (ARITH_LD…ARITH_SHL) to the shared enums.svh, next to ALU_f.
- The ALU stays instantiated at CPU level because it is shared with other CPU sequencing. This block only drives its ports.
- No sub-module: the flag logic is a few inline comparisons.

## Test plan
- V1=8'hF0, V2=8'h20, opcode 8124 → V1=8'h10, VF=1; done in cycle 6.
- V3=8'h05, V4=8'h07, opcode 8345 → V3=8'hFE, VF=0. Then V3=V4=8'h07, opcode 8345 → V3=8'h00, VF=1.
- V5=8'h81, opcode 855E → V5=8'h02, VF=1. Then V5=8'h81, opcode 8556 → V5=8'h40, VF=1.
- VF=8'h03, V1=8'h01, opcode 8F14 → two writes (F←8'h04, then F←8'h00); final VF=8'h00.
- Opcode 8128 → done+error in cycle 1, no reg_we. Opcode 8121 → V1 written, VF untouched, done in cycle 5.
- start asserted while busy is ignored. reset_n pulsed low during S_WRX → no reg_we, all outputs 0, a fresh start afterwards completes normally.

Source files
------------

// File: rtl/chip8_arith_sequencer_pkg.sv
package chip8_arith_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_f_OR,
    ALU_f_AND,
    ALU_f_XOR,
    ALU_f_ADD,
    ALU_f_MINUS,
    ALU_f_RSHIFT,
    ALU_f_LSHIFT
  } ALU_f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDX,
    S_RDY,
    S_EXEC,
    S_WRX,
    S_WRF,
    S_DONE
  } arith_state_t;

  localparam logic [3:0] ARITH_LD   = 4'h0;
  localparam logic [3:0] ARITH_OR   = 4'h1;
  localparam logic [3:0] ARITH_AND  = 4'h2;
  localparam logic [3:0] ARITH_XOR  = 4'h3;
  localparam logic [3:0] ARITH_ADD  = 4'h4;
  localparam logic [3:0] ARITH_SUB  = 4'h5;
  localparam logic [3:0] ARITH_SHR  = 4'h6;
  localparam logic [3:0] ARITH_SUBN = 4'h7;
  localparam logic [3:0] ARITH_SHL  = 4'hE;

  function automatic logic arith_legal(input logic [3:0] n);
    return (n <= ARITH_SUBN) || (n == ARITH_SHL);
  endfunction

  function automatic logic arith_sets_flag(input logic [3:0] n);
    return (n == ARITH_ADD) || (n == ARITH_SUB) || (n == ARITH_SHR) ||
           (n == ARITH_SUBN) || (n == ARITH_SHL);
  endfunction

endpackage

// File: rtl/chip8_arith_sequencer.sv
module chip8_arith_sequencer
  import chip8_arith_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  reg_raddr,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic [7:0]  reg_wdata,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output ALU_f        alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_carry
);

  arith_state_t state, state_next;

  logic [3:0] x_q, y_q, n_q;
  logic [7:0] vx_q, res_q;
  logic       flag_q, error_q;
  logic       flag_next;
  logic [7:0] vy;

  logic unused_bits;
  assign unused_bits = ^{opcode[15:12], alu_out[15:8]};

  // VY arrives from the synchronous read issued in S_RDY
  assign vy = reg_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      vx_q    <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x_q     <= opcode[11:8];
          y_q     <= opcode[7:4];
          n_q     <= opcode[3:0];
          error_q <= !arith_legal(opcode[3:0]);
        end
        S_RDY: vx_q <= reg_rdata;
        S_EXEC: begin
          res_q  <= alu_out[7:0];
          flag_q <= flag_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    error      = 1'b0;
    reg_raddr  = '0;
    reg_we     = 1'b0;
    reg_waddr  = '0;
    reg_wdata  = '0;
    alu_in1    = '0;
    alu_in2    = '0;
    alu_sel    = ALU_f_OR;
    flag_next  = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = arith_legal(opcode[3:0]) ? S_RDX : S_DONE;
      S_RDX: begin
        reg_raddr  = x_q;
        state_next = S_RDY;
      end
      S_RDY: begin
        reg_raddr  = y_q;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_WRX;
        alu_in1    = {8'h00, vx_q};
        alu_in2    = {8'h00, vy};
        case (n_q)
          ARITH_LD: begin
            alu_in1 = {8'h00, vy};
            alu_in2 = '0;
          end
          ARITH_OR:  alu_sel = ALU_f_OR;
          ARITH_AND: alu_sel = ALU_f_AND;
          ARITH_XOR: alu_sel = ALU_f_XOR;
          ARITH_ADD: begin
            alu_sel   = ALU_f_ADD;
            flag_next = alu_carry;
          end
          ARITH_SUB: begin
            alu_sel   = ALU_f_MINUS;
            flag_next = (vx_q >= vy);
          end
          ARITH_SUBN: begin
            alu_sel   = ALU_f_MINUS;
            alu_in1   = {8'h00, vy};
            alu_in2   = {8'h00, vx_q};
            flag_next = (vy >= vx_q);
          end
          ARITH_SHR: begin
            alu_sel   = ALU_f_RSHIFT;
            alu_in2   = 16'd1;
            flag_next = vx_q[0];
          end
          ARITH_SHL: begin
            alu_sel   = ALU_f_LSHIFT;
            alu_in2   = 16'd1;
            flag_next = vx_q[7];
          end
          default: ;
        endcase
      end
      S_WRX: begin
        reg_we     = 1'b1;
        reg_waddr  = x_q;
        reg_wdata  = res_q;
        state_next = arith_sets_flag(n_q) ? S_WRF : S_DONE;
      end
      S_WRF: begin
        reg_we     = 1'b1;
        reg_waddr  = 4'hF;
        reg_wdata  = {7'b0, flag_q};
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        error      = error_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_arith_sequencer.sv
module tb_chip8_arith_sequencer;
  import chip8_arith_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] opcode;
  logic        busy, done, error;
  logic [3:0]  reg_raddr;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [7:0]  reg_wdata;
  logic [15:0] alu_in1, alu_in2, alu_out;
  ALU_f        alu_sel;
  logic        alu_carry;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  rf [16] = '{default: 8'h00};
  int unsigned we_count = 0;
  logic        tb_we = 1'b0;
  logic [3:0]  tb_addr = '0;
  logic [7:0]  tb_data = '0;

  chip8_arith_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .opcode   (opcode),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .reg_raddr(reg_raddr),
    .reg_rdata(reg_rdata),
    .reg_we   (reg_we),
    .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // V register file: synchronous read, write port for the sequencer and a bench preload port
  always @(posedge clk) begin
    if (reg_we) begin
      rf[reg_waddr] <= reg_wdata;
      we_count      <= we_count + 1;
    end
    if (tb_we) rf[tb_addr] <= tb_data;
    reg_rdata <= rf[reg_raddr];
  end

  // Shared ALU; carry reports the carry out of the low byte
  logic [8:0] low_sum;
  always_comb begin
    low_sum   = {1'b0, alu_in1[7:0]} + {1'b0, alu_in2[7:0]};
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      ALU_f_OR:     alu_out = alu_in1 | alu_in2;
      ALU_f_AND:    alu_out = alu_in1 & alu_in2;
      ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
      ALU_f_ADD: begin
        alu_out   = alu_in1 + alu_in2;
        alu_carry = low_sum[8];
      end
      ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
      ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
      ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
      default:      alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] n,
                                output logic [7:0] res, output logic flag,
                                output bit wflag, output bit legal);
    int a = int'(vx);
    int b = int'(vy);
    res = '0; flag = 1'b0; wflag = 1'b0; legal = 1'b1;
    case (n)
      4'h0: res = vy;
      4'h1: res = vx | vy;
      4'h2: res = vx & vy;
      4'h3: res = vx ^ vy;
      4'h4: begin res = 8'(a + b); flag = (a + b) > 255; wflag = 1'b1; end
      4'h5: begin res = 8'(a - b); flag = (a >= b);      wflag = 1'b1; end
      4'h6: begin res = 8'(a / 2); flag = (a % 2) == 1;  wflag = 1'b1; end
      4'h7: begin res = 8'(b - a); flag = (b >= a);      wflag = 1'b1; end
      4'hE: begin res = 8'(a * 2); flag = (a >= 128);    wflag = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] op, input bit spam);
    logic [7:0]  exp_rf [16];
    logic [7:0]  res;
    logic        flag;
    bit          wflag, legal;
    int unsigned w0, exp_cycles, exp_writes, cyc;
    logic [3:0]  x, y;
    x = op[11:8];
    y = op[7:4];
    model(rf[x], rf[y], op[3:0], res, flag, wflag, legal);
    exp_rf = rf;
    if (legal) begin
      exp_rf[x] = res;
      if (wflag) exp_rf[15] = {7'b0, flag};
    end
    exp_cycles = !legal ? 1 : (wflag ? 6 : 5);
    exp_writes = !legal ? 0 : (wflag ? 2 : 1);
    w0 = we_count;
    check($sformatf("idle_busy_%h", op), 32'(busy), 32'd0);
    opcode = op; start = 1'b1;
    @(posedge clk); #1;
    if (spam) opcode = 16'h8FF4;
    else start = 1'b0;
    check($sformatf("busy_c1_%h", op), 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("done_cycle_%h", op), cyc, exp_cycles);
    check($sformatf("error_%h", op), 32'(error), 32'(!legal));
    start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("busy_after_%h", op), 32'(busy), 32'd0);
    check($sformatf("done_after_%h", op), 32'(done), 32'd0);
    check($sformatf("writes_%h", op), we_count - w0, exp_writes);
    for (int i = 0; i < 16; i++)
      check($sformatf("rf%0d_%h", i, op), 32'(rf[i]), 32'(exp_rf[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned w0;
    reset_n = 1'b0; start = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_error",   32'(error),     32'd0);
    check("rst_we",      32'(reg_we),    32'd0);
    check("rst_raddr",   32'(reg_raddr), 32'd0);
    check("rst_waddr",   32'(reg_waddr), 32'd0);
    check("rst_wdata",   32'(reg_wdata), 32'd0);
    check("rst_alu_in1", 32'(alu_in1),   32'd0);
    check("rst_alu_in2", 32'(alu_in2),   32'd0);
    check("rst_alu_sel", 32'(alu_sel),   32'(ALU_f_OR));
    reset_n = 1'b1;
    @(posedge clk); #1;

    poke(1, 8'hF0); poke(2, 8'h20);
    run_op(16'h8124, 0);
    check("plan_8124_v1", 32'(rf[1]), 32'h10);
    check("plan_8124_vf", 32'(rf[15]), 32'h01);

    poke(3, 8'h05); poke(4, 8'h07);
    run_op(16'h8345, 0);
    check("plan_8345_v3", 32'(rf[3]), 32'hFE);
    check("plan_8345_vf", 32'(rf[15]), 32'h00);
    poke(3, 8'h07);
    run_op(16'h8345, 0);
    check("plan_8345eq_v3", 32'(rf[3]), 32'h00);
    check("plan_8345eq_vf", 32'(rf[15]), 32'h01);

    poke(5, 8'h81);
    run_op(16'h855E, 0);
    check("plan_855E_v5", 32'(rf[5]), 32'h02);
    check("plan_855E_vf", 32'(rf[15]), 32'h01);
    poke(5, 8'h81);
    run_op(16'h8556, 0);
    check("plan_8556_v5", 32'(rf[5]), 32'h40);
    check("plan_8556_vf", 32'(rf[15]), 32'h01);

    poke(15, 8'h03); poke(1, 8'h01);
    run_op(16'h8F14, 0);
    check("plan_8F14_vf", 32'(rf[15]), 32'h00);

    poke(7, 8'h5A);
    run_op(16'h8775, 0);
    check("xy_8775_v7", 32'(rf[7]), 32'h00);
    check("xy_8775_vf", 32'(rf[15]), 32'h01);
    poke(6, 8'h31);
    run_op(16'h8664, 0);
    check("xy_8664_v6", 32'(rf[6]), 32'h62);

    run_op(16'h8128, 0);
    poke(15, 8'hA5); poke(1, 8'h0C); poke(2, 8'h03);
    run_op(16'h8121, 0);
    check("plan_8121_v1", 32'(rf[1]), 32'h0F);
    check("plan_8121_vf", 32'(rf[15]), 32'hA5);

    run_op(16'h8232, 1);

    // reset while the sequencer sits in S_WRX
    poke(1, 8'hF0); poke(2, 8'h20);
    opcode = 16'h8124; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_we_before_rst", 32'(reg_we), 32'd1);
    w0 = we_count;
    reset_n = 1'b0;
    #1;
    check("mid_busy",  32'(busy),      32'd0);
    check("mid_we",    32'(reg_we),    32'd0);
    check("mid_waddr", 32'(reg_waddr), 32'd0);
    check("mid_wdata", 32'(reg_wdata), 32'd0);
    check("mid_in1",   32'(alu_in1),   32'd0);
    check("mid_done",  32'(done),      32'd0);
    repeat (2) @(posedge clk);
    #3;
    check("mid_no_write", we_count - w0, 32'd0);
    check("mid_v1_kept",  32'(rf[1]),    32'hF0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h8124, 0);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] x, y, n;
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      n = 4'($urandom_range(0, 15));
      poke(x, 8'($urandom));
      if (y != x) poke(y, 8'($urandom));
      run_op({4'h8, x, y, n}, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
